// File: rtl/ex_mdu_stage_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package ex_mdu_stage_pkg;

  // Multiply operand signedness (bit0: rs1 signed, bit1: rs2 signed)
  localparam logic [1:0] UNSIGNED_UNSIGNED = 2'b00;
  localparam logic [1:0] SIGNED_UNSIGNED   = 2'b01;
  localparam logic [1:0] SIGNED_SIGNED     = 2'b11;

  // Multiply product half select
  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Divide result select
  localparam logic QUOTIENT  = 1'b0;
  localparam logic REMAINDER = 1'b1;

  // Iterative divider states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider: IDLE -> CALC (XLEN steps) -> DONE -> IDLE.
// Works on magnitudes; signs are recorded at start and applied on the way out.
// Divide-by-zero and signed overflow produce the architectural results
// naturally from the restoring loop. With MDU_DIV_FAST_EN defined those two
// cases skip CALC and go straight to DONE with identical results.
module mdu_div_iter
  import ex_mdu_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            ack,
  input  logic            div_sign,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_e           state_q, state_n;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0]      quo_q, quo_n, rem_q, rem_n, dvsr_q, dvsr_n;
  logic                 q_neg_q, q_neg_n, r_neg_q, r_neg_n;
  logic                 dvd_neg, dvs_neg;
  logic [XLEN-1:0]      dividend_abs, divisor_abs;
  logic [XLEN:0]        shifted, diff;

  assign dvd_neg      = div_sign && dividend[XLEN-1];
  assign dvs_neg      = div_sign && divisor[XLEN-1];
  assign dividend_abs = dvd_neg ? -dividend : dividend;
  assign divisor_abs  = dvs_neg ? -divisor  : divisor;

  // One restoring step: shift next dividend bit into the partial remainder
  // and try to subtract; the borrow bit says whether the subtract fits.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

`ifdef MDU_DIV_FAST_EN
  logic div_zero, div_ovf;
  assign div_zero = (divisor == '0);
  assign div_ovf  = div_sign && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
`endif

  // Next-state and datapath update
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    quo_n   = quo_q;
    rem_n   = rem_q;
    dvsr_n  = dvsr_q;
    q_neg_n = q_neg_q;
    r_neg_n = r_neg_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          quo_n   = dividend_abs;
          rem_n   = '0;
          dvsr_n  = divisor_abs;
          cnt_n   = '0;
          // A zero divisor must leave the all-ones quotient untouched.
          q_neg_n = (dvd_neg ^ dvs_neg) && (divisor != '0);
          r_neg_n = dvd_neg;
          state_n = DIV_CALC;
`ifdef MDU_DIV_FAST_EN
          if (div_zero) begin
            quo_n   = '1;
            rem_n   = dividend;
            q_neg_n = 1'b0;
            r_neg_n = 1'b0;
            state_n = DIV_DONE;
          end else if (div_ovf) begin
            quo_n   = dividend;
            rem_n   = '0;
            q_neg_n = 1'b0;
            r_neg_n = 1'b0;
            state_n = DIV_DONE;
          end
`endif
        end
      end
      DIV_CALC: begin
        if (!diff[XLEN]) begin
          rem_n = diff[XLEN-1:0];
          quo_n = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_n = shifted[XLEN-1:0];
          quo_n = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_n = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(XLEN-1)) state_n = DIV_DONE;
      end
      DIV_DONE: begin
        if (ack) state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
    if (abort) begin
      state_n = DIV_IDLE;
      cnt_n   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      quo_q   <= quo_n;
      rem_q   <= rem_n;
      dvsr_q  <= dvsr_n;
      q_neg_q <= q_neg_n;
      r_neg_q <= r_neg_n;
    end
  end

  assign busy      = (state_q == DIV_CALC);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = q_neg_q ? -quo_q : quo_q;
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_mdu_stage.sv
// EX stage for M-extension ops: owns the EX valid bit, does MUL* in one cycle
// and DIV*/REM* on the iterative divider, holding EX until the divide is done.
// Optional: define MDU_DIV_FAST_EN to short-circuit divide-by-zero and signed
// overflow in the divider.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_flush,
  input  logic            id_ex_valid,
  input  logic            mem_allowin,
  output logic            ex_allowin,
  output logic            ex_valid,
  output logic            ex_mem_valid,
  input  logic            ex_is_mul_inst,
  input  logic            ex_is_div_inst,
  input  logic [1:0]      ex_sign_extend,
  input  logic            ex_word_sel,
  input  logic            ex_div_sign,
  input  logic            ex_div_res_sel,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_busy
);

  logic              ex_ready_go;
  logic              div_start, div_ack, div_done;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic              rs1_signed, rs2_signed;
  logic [2*XLEN-1:0] mul_a, mul_b, product;

  // Handshake: a divide holds EX until the divider reports DONE.
  assign ex_ready_go  = !(ex_valid && ex_is_div_inst) || div_done;
  assign ex_allowin   = !ex_valid || (ex_ready_go && mem_allowin);
  assign ex_mem_valid = ex_valid && ex_ready_go;

  // EX valid bit: flush wins, then accept from ID when allowed
  always_ff @(posedge clk) begin
    if (rst)              ex_valid <= 1'b0;
    else if (pipe_flush)  ex_valid <= 1'b0;
    else if (ex_allowin)  ex_valid <= id_ex_valid;
  end

  // Operand signedness decode
  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    case (ex_sign_extend)
      SIGNED_SIGNED:     begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
      SIGNED_UNSIGNED:   rs1_signed = 1'b1;
      UNSIGNED_UNSIGNED: ;
      default:           ;
    endcase
  end

  // Low 2*XLEN bits of a product of sign-extended operands equal the exact
  // signed/unsigned/mixed product, so one unsigned multiplier covers all cases.
  assign mul_a   = {{XLEN{rs1_signed && ex_rs1[XLEN-1]}}, ex_rs1};
  assign mul_b   = {{XLEN{rs2_signed && ex_rs2[XLEN-1]}}, ex_rs2};
  assign product = mul_a * mul_b;

  assign div_start = ex_valid && ex_is_div_inst;
  assign div_ack   = ex_mem_valid && mem_allowin;

  mdu_div_iter #(
    .XLEN      (XLEN),
    .DIV_CNT_W (DIV_CNT_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (pipe_flush),
    .ack       (div_ack),
    .div_sign  (ex_div_sign),
    .dividend  (ex_rs1),
    .divisor   (ex_rs2),
    .busy      (mdu_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Result mux, zero whenever nothing is being presented to MEM
  always_comb begin
    mdu_result = '0;
    if (ex_mem_valid) begin
      if (ex_is_mul_inst)
        mdu_result = (ex_word_sel == HIGH) ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
      else if (ex_is_div_inst)
        mdu_result = (ex_div_res_sel == QUOTIENT) ? div_quo : div_rem;
    end
  end

endmodule
